nes_pad_reader: RTL and testbench

//  Reads one NES controller (4021 shift register) and presents the 8 button states to user logic.
//  - Drives the pad latch/clock lines and samples the serial data line once per poll period.
//  - Counterpart input path to the LED blinker outputs.
//  - Per-button press pulses are suitable for driving single-cycle controls such as pause.

---
 rtl/nes_pad_pkg.sv | 34 +++
 rtl/nes_pad_sync.sv | 38 +++
 rtl/nes_pad_reader.sv | 190 +++++++++++++++++++
 tb/tb_nes_pad_reader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : nes_pad_pkg                                                  |
// | Description : Shared types and constants for the NES controller reader.    |
// |               Button bit positions follow the 4021 shift-out order, so the |
// |               first serial bit (A) lands in bit 0.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } pad_state_t;

  typedef logic [7:0] pad_buttons_t;

  localparam int BTN_A        = 0;
  localparam int BTN_B        = 1;
  localparam int BTN_SELECT   = 2;
  localparam int BTN_START    = 3;
  localparam int BTN_UP       = 4;
  localparam int BTN_DOWN     = 5;
  localparam int BTN_LEFT     = 6;
  localparam int BTN_RIGHT    = 7;

  // Half-bit phases of pad activity per frame: 2 latch + 8 low + 7 high.
  localparam int FRAME_PHASES = 17;

endpackage : nes_pad_pkg
`default_nettype wire

// File: rtl/nes_pad_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nes_pad_sync                                                 |
// | Description : Two-flop synchronizer for the asynchronous pad data line.    |
// |               Resets to 1 because an idle, active-low pad line means       |
// |               "not pressed".                                               |
// | Ports       : clk     - system clock                                       |
// |               reset_n - asynchronous active-low reset                      |
// |               d       - asynchronous input                                 |
// |               q       - synchronized output                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nes_pad_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule : nes_pad_sync
`default_nettype wire

// File: rtl/nes_pad_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nes_pad_reader                                               |
// | Description : Polls one NES controller (4021 shift register) once per poll |
// |               period and presents the 8 button states, a frame-valid pulse |
// |               and per-button press pulses.                                 |
// | Parameters  : PHASE_CYCLES - clk cycles per half-bit phase (>= 4)          |
// |               POLL_CYCLES  - clk cycles between frame starts               |
// |                              (> 17 * PHASE_CYCLES)                         |
// | Ports       : clk, reset_n (async active-low), enable (allows new frames), |
// |               pad_data (active-low serial in), pad_latch / pad_clk (pad    |
// |               strobes), buttons (active-high state, A = bit 0), valid      |
// |               (1-cycle update pulse), pressed (rising-edge pulses).        |
// | Option      : NES_PAD_DEBOUNCE_EN - accept a frame only when it matches    |
// |               the previous candidate frame.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int PHASE_CYCLES = 300,
  parameter int POLL_CYCLES  = 833334
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic [7:0] pressed
);

  localparam int LATCH_CYCLES = 2 * PHASE_CYCLES;
  localparam int PHASE_W      = $clog2(LATCH_CYCLES);
  localparam int POLL_W       = $clog2(POLL_CYCLES);

  localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(PHASE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LATCH_LAST  = PHASE_W'(LATCH_CYCLES - 1);
  localparam logic [POLL_W-1:0]  POLL_RELOAD = POLL_W'(POLL_CYCLES - 1);
  localparam logic [2:0]         IDX_LAST    = 3'(BTN_RIGHT);

  if (PHASE_CYCLES < 4) begin : g_phase_check
    $error("nes_pad_reader: PHASE_CYCLES must be at least 4");
  end
  if (POLL_CYCLES <= FRAME_PHASES * PHASE_CYCLES) begin : g_poll_check
    $error("nes_pad_reader: POLL_CYCLES must exceed 17*PHASE_CYCLES");
  end

  pad_state_t         state_q,     state_d;
  logic [PHASE_W-1:0] phase_q,     phase_d;
  logic [2:0]         idx_q,       idx_d;
  logic [POLL_W-1:0]  poll_q,      poll_d;
  pad_buttons_t       cand_q,      cand_d;
  pad_buttons_t       buttons_q,   buttons_d;
  pad_buttons_t       pressed_q,   pressed_d;
  logic               valid_q,     valid_d;
  logic               pad_latch_q, pad_latch_d;
  logic               pad_clk_q,   pad_clk_d;
  pad_buttons_t       accepted;
`ifdef NES_PAD_DEBOUNCE_EN
  pad_buttons_t       prev_q,      prev_d;
`endif

  logic pad_data_s;

  nes_pad_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pad_data),
    .q       (pad_data_s)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    cand_d    = cand_q;
    buttons_d = buttons_q;
    pressed_d = '0;
    valid_d   = 1'b0;
    accepted  = buttons_q;
`ifdef NES_PAD_DEBOUNCE_EN
    prev_d    = prev_q;
`endif
    // The poll counter free-runs down to 0 and waits there for the next start.
    poll_d    = (poll_q != '0) ? (poll_q - POLL_W'(1)) : poll_q;

    case (state_q)
      IDLE: begin
        if ((poll_q == '0) && enable) begin
          state_d = LATCH;
          phase_d = '0;
          poll_d  = POLL_RELOAD;
        end
      end
      LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = LOW;
          phase_d = '0;
          idx_d   = '0;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      LOW: begin
        if (phase_q == PHASE_LAST) begin
          // Sample as late as possible so the synchronizer has settled.
          cand_d[idx_q] = ~pad_data_s;
          phase_d       = '0;
          state_d       = (idx_q == IDX_LAST) ? DONE : HIGH;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      HIGH: begin
        if (phase_q == PHASE_LAST) begin
          state_d = LOW;
          phase_d = '0;
          idx_d   = idx_q + 3'd1;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      DONE: begin
`ifdef NES_PAD_DEBOUNCE_EN
        // Two identical consecutive candidates are required; a single-frame
        // glitch leaves the accepted state untouched.
        accepted = (cand_q == prev_q) ? cand_q : buttons_q;
        prev_d   = cand_q;
`else
        accepted = cand_q;
`endif
        buttons_d = accepted;
        pressed_d = accepted & ~buttons_q;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are registered from the next state so they track the FSM
    // without combinational glitches on the pad lines.
    pad_latch_d = (state_d == LATCH);
    pad_clk_d   = (state_d == HIGH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      idx_q       <= '0;
      poll_q      <= '0;
      cand_q      <= '0;
      buttons_q   <= '0;
      pressed_q   <= '0;
      valid_q     <= 1'b0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b0;
`ifdef NES_PAD_DEBOUNCE_EN
      prev_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      poll_q      <= poll_d;
      cand_q      <= cand_d;
      buttons_q   <= buttons_d;
      pressed_q   <= pressed_d;
      valid_q     <= valid_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
`ifdef NES_PAD_DEBOUNCE_EN
      prev_q      <= prev_d;
`endif
    end
  end

  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign buttons   = buttons_q;
  assign pressed   = pressed_q;
  assign valid     = valid_q;

endmodule : nes_pad_reader
`default_nettype wire

// File: tb/tb_nes_pad_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nes_pad_reader                                            |
// | Description : Self-checking bench for nes_pad_reader with a 4021 pad model |
// |               and a frame scoreboard (expected result queued at each       |
// |               latch rise, compared when valid pulses).                     |
// | Option      : NES_PAD_DEBOUNCE_EN - selects the debounced reference model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nes_pad_reader;
  import nes_pad_pkg::*;

  localparam int PHASE  = 4;
  localparam int POLL   = 100;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       valid;
  logic [7:0] pressed;

  always #5 clk = ~clk;

  nes_pad_reader #(
    .PHASE_CYCLES (PHASE),
    .POLL_CYCLES  (POLL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .buttons   (buttons),
    .valid     (valid),
    .pressed   (pressed)
  );

  // 4021 model: parallel load on latch, shift toward bit 0 on pad_clk rise.
  logic [7:0] pad_btns = 8'h00;   // active-high pressed buttons held on the pad
  logic [7:0] pad_sh   = 8'hFF;
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pad_sh <= ~pad_btns;
    else           pad_sh <= {1'b1, pad_sh[7:1]};
  end
  assign pad_data = pad_sh[0];

  int tests = 0;
  int fails = 0;

  // Reference model and scoreboard
  logic [7:0]  m_btn = 8'h00;
`ifdef NES_PAD_DEBOUNCE_EN
  logic [7:0]  m_prev = 8'h00;
`endif
  logic [15:0] sb_q[$];

  // Monitor state
  int   cyc = 0;
  int   latch_run = 0;
  int   hi_run = 0;
  int   pulses = 0;
  int   last_valid = 0;
  int   act_cnt = 0;
  logic latch_prev = 1'b0;
  logic clk_prev = 1'b0;
  logic valid_seen = 1'b0;
  logic latch_rise = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected();
    logic [7:0] acc;
`ifdef NES_PAD_DEBOUNCE_EN
    acc    = (pad_btns == m_prev) ? pad_btns : m_btn;
    m_prev = pad_btns;
`else
    acc    = pad_btns;
`endif
    sb_q.push_back({acc, acc & ~m_btn});
    m_btn = acc;
  endtask

  // One clock of observation, sampled on the falling edge.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    cyc++;
    valid_seen = valid;
    latch_rise = 1'b0;
    if (!reset_n) begin
      latch_run  = 0;
      hi_run     = 0;
      pulses     = 0;
      last_valid = 0;
      latch_prev = 1'b0;
      clk_prev   = 1'b0;
    end else begin
      latch_rise = pad_latch && !latch_prev;
      if (latch_rise) begin
        push_expected();
        pulses = 0;
      end
      check("latch_clk_overlap", {31'd0, pad_latch & pad_clk}, 32'd0);
      if (pad_latch || pad_clk) act_cnt++;
      if (pad_latch) latch_run++;
      else if (latch_prev) begin
        check("latch_width", latch_run, 8);
        latch_run = 0;
      end
      if (pad_clk) begin
        hi_run++;
        if (!clk_prev) pulses++;
      end else if (clk_prev) begin
        check("clk_high_width", hi_run, PHASE);
        hi_run = 0;
      end
      if (!enable) last_valid = 0;
      if (valid) begin
        check("clk_pulses", pulses, 7);
        if (last_valid > 0) check("valid_period", cyc - last_valid, POLL);
        last_valid = cyc;
        check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("buttons", {24'd0, buttons}, {24'd0, e[15:8]});
          check("pressed", {24'd0, pressed}, {24'd0, e[7:0]});
        end
      end else begin
        check("pressed_idle", {24'd0, pressed}, 32'd0);
      end
      latch_prev = pad_latch;
      clk_prev   = pad_clk;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid_seen && n < 3 * POLL);
    check("valid_timeout", {31'd0, valid_seen}, 32'd1);
  endtask

  task automatic wait_latch_rise();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!latch_rise && n < 3 * POLL);
    check("latch_timeout", {31'd0, latch_rise}, 32'd1);
  endtask

  initial begin
    logic [7:0] a_start;
    logic [7:0] up_only;
    logic [7:0] b_only;
    a_start = 8'h00;
    a_start[BTN_A]     = 1'b1;
    a_start[BTN_START] = 1'b1;
    up_only = 8'h00;
    up_only[BTN_UP]    = 1'b1;
    b_only  = 8'h00;
    b_only[BTN_B]      = 1'b1;

    // 1: reset, enable low, no pad activity
    run(5);
    reset_n = 1'b1;
    tick();
    check("rst_buttons", {24'd0, buttons}, 32'd0);
    check("rst_valid",   {31'd0, valid},     32'd0);
    check("rst_latch",   {31'd0, pad_latch}, 32'd0);
    check("rst_clk",     {31'd0, pad_clk},   32'd0);
    act_cnt = 0;
    run(200);
    check("idle_activity", act_cnt, 0);

    // 2-4: A+Start held for several frames, then Up only, then release
    pad_btns = a_start;
    enable   = 1'b1;
    tick();
    check("first_latch", {31'd0, pad_latch}, 32'd1);
    for (int f = 0; f < 3; f++) wait_valid();
    pad_btns = up_only;
    for (int f = 0; f < 2; f++) wait_valid();
    pad_btns = 8'h00;
    for (int f = 0; f < 2; f++) wait_valid();

    // 6: B for exactly one frame
    pad_btns = b_only;
    wait_valid();
    pad_btns = 8'h00;
    for (int f = 0; f < 2; f++) wait_valid();

    // 5: reset in the middle of a frame
    pad_btns = up_only;
    for (int f = 0; f < 2; f++) wait_valid();
    wait_latch_rise();
    run(19);
    check("pre_reset_buttons", {24'd0, buttons}, {24'd0, m_btn});
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_latch",   {31'd0, pad_latch}, 32'd0);
    check("arst_clk",     {31'd0, pad_clk},   32'd0);
    check("arst_buttons", {24'd0, buttons},   32'd0);
    check("arst_valid",   {31'd0, valid},     32'd0);
    sb_q.delete();
    m_btn = 8'h00;
`ifdef NES_PAD_DEBOUNCE_EN
    m_prev = 8'h00;
`endif
    run(3);
    reset_n = 1'b1;
    tick();
    check("fresh_latch", {31'd0, pad_latch}, 32'd1);
    for (int f = 0; f < 2; f++) wait_valid();

    // enable dropped mid-frame: frame completes, nothing further starts
    wait_latch_rise();
    run(10);
    enable = 1'b0;
    wait_valid();
    act_cnt = 0;
    run(200);
    check("disabled_activity", act_cnt, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_nes_pad_reader
`default_nettype wire
